// File: rtl/cnt_bcd_disp_if.sv
// Display-side bundle between the count source and the BCD/7-segment driver.
// master drives the binary count; slave returns BCD, status and pin drive.
interface cnt_bcd_disp_if;
   logic [7:0] din;
   logic [9:0] bcd;
   logic       upd;
   logic       ovr;
   logic [6:0] seg;
   logic [2:0] dig;

   modport master (output din, input bcd, upd, ovr, seg, dig);
   modport slave  (input din, output bcd, upd, ovr, seg, dig);
endinterface

// File: rtl/cnt_bcd_disp.sv
// Binary count -> 3-digit BCD via a sequential double-dabble engine, driving a
// time-multiplexed 7-segment display with leading-zero blanking.
module cnt_bcd_disp #(
   parameter int SCAN_DIV    = 16,
   parameter bit SEG_ACT_LOW = 1'b1
) (
   input  logic            clk,
   input  logic            rstx,
   cnt_bcd_disp_if.slave   bus
);

   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
   localparam logic [6:0]  SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;
   localparam logic [2:0]  DIG_OFF   = SEG_ACT_LOW ? 3'b111 : 3'b000;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state_q, state_d;
   logic        ld, sh, fin;
   logic [7:0]  sr_q;
   logic [9:0]  scr_q;
   logic [3:0]  iter_q;
   logic [8:0]  adj;
   logic [9:0]  bcd_q;
   logic        upd_q, ovr_q;

   // ---------------- conversion FSM ----------------
   always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ld      = 1'b0;
      sh      = 1'b0;
      fin     = 1'b0;
      case (state_q)
         IDLE: begin
            ld      = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            sh = 1'b1;
            if (iter_q == 4'd1) state_d = DONE;
         end
         DONE: begin
            fin     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Hundreds never exceeds 1 before the last shift, so only its low bit
   // feeds the shifted result and it needs no add-3 correction.
   always_comb begin
      adj[8]   = scr_q[8];
      adj[7:4] = (scr_q[7:4] >= 4'd5) ? scr_q[7:4] + 4'd3 : scr_q[7:4];
      adj[3:0] = (scr_q[3:0] >= 4'd5) ? scr_q[3:0] + 4'd3 : scr_q[3:0];
   end

   always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) begin
         sr_q   <= '0;
         scr_q  <= '0;
         iter_q <= '0;
      end else if (ld) begin
         sr_q   <= bus.din;
         scr_q  <= '0;
         iter_q <= 4'd8;
      end else if (sh) begin
         scr_q  <= {adj, sr_q[7]};
         sr_q   <= {sr_q[6:0], 1'b0};
         iter_q <= iter_q - 4'd1;
      end
   end

   // Result lands together with its upd pulse; scratch never leaks to bcd.
   always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) begin
         bcd_q <= '0;
         upd_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         upd_q <= fin;
         if (fin) begin
            bcd_q <= scr_q;
            ovr_q <= (scr_q[9:8] >= 2'd2);
         end
      end
   end

   // ---------------- digit scan ----------------
   logic [15:0] scan_q;
   logic [1:0]  idx_q;
   logic        wrap;

   assign wrap = (scan_q == SCAN_LAST);

   always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) begin
         scan_q <= '0;
         idx_q  <= '0;
      end else begin
         scan_q <= wrap ? 16'd0 : scan_q + 16'd1;
         if (wrap) idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
   end

   // ---------------- segment decode ----------------
   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    seg7 = 7'b0111111;
         4'd1:    seg7 = 7'b0000110;
         4'd2:    seg7 = 7'b1011011;
         4'd3:    seg7 = 7'b1001111;
         4'd4:    seg7 = 7'b1100110;
         4'd5:    seg7 = 7'b1101101;
         4'd6:    seg7 = 7'b1111101;
         4'd7:    seg7 = 7'b0000111;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1101111;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   logic [2:0][3:0] nib;
   logic [2:0]      blank;
   logic [2:0][6:0] seg_dig;
   logic [6:0]      seg_sel;
   logic [2:0]      dig_sel;
   logic [6:0]      seg_q;
   logic [2:0]      dig_q;

   assign nib   = {{2'b00, bcd_q[9:8]}, bcd_q[7:4], bcd_q[3:0]};
   assign blank = {(bcd_q[9:8] == 2'd0),
                   (bcd_q[9:8] == 2'd0) && (bcd_q[7:4] == 4'd0),
                   1'b0};

   for (genvar g = 0; g < 3; g++) begin : g_dig
      assign seg_dig[g] = blank[g] ? 7'h00 : seg7(nib[g]);
   end

   always_comb begin
      seg_sel = seg_dig[0];
      dig_sel = 3'b001;
      case (idx_q)
         2'd1: begin seg_sel = seg_dig[1]; dig_sel = 3'b010; end
         2'd2: begin seg_sel = seg_dig[2]; dig_sel = 3'b100; end
         default: ;
      endcase
   end

   // Polarity is applied at the pin register so the decode stays active-high.
   always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) begin
         seg_q <= SEG_OFF;
         dig_q <= DIG_OFF;
      end else begin
         seg_q <= seg_sel ^ SEG_OFF;
         dig_q <= dig_sel ^ DIG_OFF;
      end
   end

   assign bus.bcd = bcd_q;
   assign bus.upd = upd_q;
   assign bus.ovr = ovr_q;
   assign bus.seg = seg_q;
   assign bus.dig = dig_q;

endmodule
